dram_row_controller: RTL and testbench

//  Sequencer directly upstream of the DRAM cell array: turns host read/write requests into
//  one-hot per-row WriteEdge/ReadEdge pulses and periodic RefreshEdge pulses for ROWS rows
//  of WIDTH cells. It drives the shared cell data-in bus and samples the shared cell data-out bus.
//  It arbitrates host traffic against refresh so that every row is refreshed once per ROWS intervals.

---
 rtl/dram_row_controller_if.sv | 25 ++
 rtl/dram_row_controller.sv | 191 +++++++++++++++++++
 tb/tb_dram_row_controller.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_row_controller_if.sv
// Host request/response channel of the DRAM row controller.
//   master : host side   - drives ReqValid/ReqWrite/ReqAddr/ReqWData, sees ReqReady/RspValid/RspRData
//   slave  : controller  - sees the request fields, drives ReqReady/RspValid/RspRData
interface dram_row_controller_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned WIDTH  = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic [WIDTH-1:0]  ReqWData;
    logic              RspValid;
    logic [WIDTH-1:0]  RspRData;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData,
        input  ReqReady, RspValid, RspRData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData,
        output ReqReady, RspValid, RspRData
    );
endinterface

// File: rtl/dram_row_controller.sv
// DRAM row controller: sequences host reads/writes into one-hot per-row
// WriteEdge/ReadEdge pulses and interleaves periodic RefreshEdge pulses.
// Optional feature: define DRAM_REFRESH_BURST_EN to refresh all rows back-to-back
// per refresh request; otherwise one row is refreshed per request.
// Ports:
//   Clock, nReset   clock and asynchronous active-low reset
//   host            request/response channel (dram_row_controller_if.slave)
//   WriteEdge       one-hot write strobe to rows
//   ReadEdge        one-hot read strobe to rows
//   RefreshEdge     one-hot (or zero) refresh strobe to rows
//   CellInputData   data-in bus to cells, non-zero only while writing
//   CellOutputData  data-out bus from cells, sampled at the end of a read pulse
//   Busy            controller not idle
//   RefreshOverrun  one-cycle pulse when an interval expires with refresh still pending
module dram_row_controller #(
    parameter int unsigned ROWS             = 8,
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned ADDR_W           = 3,
    parameter int unsigned PULSE_CYCLES     = 2,
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic                    Clock,
    input  logic                    nReset,
    dram_row_controller_if.slave    host,
    output logic [ROWS-1:0]         WriteEdge,
    output logic [ROWS-1:0]         ReadEdge,
    output logic [ROWS-1:0]         RefreshEdge,
    output logic [WIDTH-1:0]        CellInputData,
    input  logic [WIDTH-1:0]        CellOutputData,
    output logic                    Busy,
    output logic                    RefreshOverrun
);

    localparam int unsigned CNT_W   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned TIMER_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        REFRESH = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    pulseCount;
    logic [TIMER_W-1:0]  timer;
    logic [ADDR_W-1:0]   refreshRow;
    logic [ADDR_W-1:0]   latchedAddr;
    logic                refreshPending;

    logic                terminal;
    logic                lastPulse;
    logic                enteringRefresh;
    logic                latchedInRange;
    logic [ADDR_W-1:0]   nextRefreshRow;

    // One-hot row select; out-of-range addresses select nothing.
    function automatic logic [ROWS-1:0] rowDecode(input logic [ADDR_W-1:0] a);
        logic [ROWS-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            d[i] = (32'(a) == i);
        end
        return d;
    endfunction

    assign terminal        = (timer == TIMER_W'(REFRESH_INTERVAL - 1));
    assign lastPulse       = (pulseCount == CNT_W'(PULSE_CYCLES - 1));
    assign enteringRefresh = (state == IDLE) && refreshPending;
    assign latchedInRange  = (32'(latchedAddr) < ROWS);
    assign nextRefreshRow  = (refreshRow == ADDR_W'(ROWS - 1)) ? '0 : refreshRow + ADDR_W'(1);

    // Refresh has priority: host is held off whenever a refresh is owed.
    assign host.ReqReady = (state == IDLE) && !refreshPending;

    // Sequencer, refresh timer and registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state          <= IDLE;
            pulseCount     <= '0;
            timer          <= '0;
            refreshRow     <= '0;
            latchedAddr    <= '0;
            refreshPending <= 1'b0;
            WriteEdge      <= '0;
            ReadEdge       <= '0;
            RefreshEdge    <= '0;
            CellInputData  <= '0;
            Busy           <= 1'b0;
            RefreshOverrun <= 1'b0;
            host.RspValid  <= 1'b0;
            host.RspRData  <= '0;
        end else begin
            timer <= terminal ? '0 : timer + TIMER_W'(1);

            // A refresh starting this cycle counts as served, so no overrun for it.
            RefreshOverrun <= terminal && refreshPending && !enteringRefresh;
            if (terminal) begin
                refreshPending <= 1'b1;
            end else if (enteringRefresh) begin
                refreshPending <= 1'b0;
            end

            host.RspValid <= 1'b0;

            case (state)
                IDLE: begin
                    pulseCount <= '0;
                    if (refreshPending) begin
                        state <= REFRESH;
                        Busy  <= 1'b1;
`ifdef DRAM_REFRESH_BURST_EN
                        refreshRow  <= '0;
                        RefreshEdge <= rowDecode('0);
`else
                        RefreshEdge <= rowDecode(refreshRow);
`endif
                    end else if (host.ReqValid) begin
                        latchedAddr <= host.ReqAddr;
                        Busy        <= 1'b1;
                        if (host.ReqWrite) begin
                            state         <= WRITE;
                            WriteEdge     <= rowDecode(host.ReqAddr);
                            CellInputData <= host.ReqWData;
                        end else begin
                            state    <= READ;
                            ReadEdge <= rowDecode(host.ReqAddr);
                        end
                    end
                end

                WRITE: begin
                    if (lastPulse) begin
                        state         <= RECOVER;
                        WriteEdge     <= '0;
                        CellInputData <= '0;
                    end else begin
                        pulseCount <= pulseCount + CNT_W'(1);
                    end
                end

                READ: begin
                    if (lastPulse) begin
                        state         <= RECOVER;
                        ReadEdge      <= '0;
                        host.RspValid <= 1'b1;
                        host.RspRData <= latchedInRange ? CellOutputData : '0;
                    end else begin
                        pulseCount <= pulseCount + CNT_W'(1);
                    end
                end

                REFRESH: begin
                    if (lastPulse) begin
                        refreshRow <= nextRefreshRow;
`ifdef DRAM_REFRESH_BURST_EN
                        // Walk every row without a gap; the last row ends the burst.
                        if (refreshRow == ADDR_W'(ROWS - 1)) begin
                            state       <= RECOVER;
                            RefreshEdge <= '0;
                        end else begin
                            pulseCount  <= '0;
                            RefreshEdge <= rowDecode(nextRefreshRow);
                        end
`else
                        state       <= RECOVER;
                        RefreshEdge <= '0;
`endif
                    end else begin
                        pulseCount <= pulseCount + CNT_W'(1);
                    end
                end

                RECOVER: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    Busy        <= 1'b0;
                    WriteEdge   <= '0;
                    ReadEdge    <= '0;
                    RefreshEdge <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_row_controller.sv
// Directed bench for dram_row_controller: main instance at default parameters,
// plus a REFRESH_INTERVAL=4 instance under continuous reads and a
// REFRESH_INTERVAL=2 instance that is guaranteed to overrun.
module tb_dram_row_controller;

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    always #5 Clock = ~Clock;

    // Main instance
    dram_row_controller_if #(.ADDR_W(3), .WIDTH(8)) h1 ();
    logic [7:0] writeEdge, readEdge, refreshEdge, cellIn, cellOut;
    logic       busy, overrun;

    dram_row_controller dut (
        .Clock(Clock), .nReset(nReset), .host(h1),
        .WriteEdge(writeEdge), .ReadEdge(readEdge), .RefreshEdge(refreshEdge),
        .CellInputData(cellIn), .CellOutputData(cellOut),
        .Busy(busy), .RefreshOverrun(overrun)
    );

    // Short-interval instance, host always requesting reads
    dram_row_controller_if #(.ADDR_W(3), .WIDTH(8)) h2 ();
    logic [7:0] we2, re2, rf2, ci2;
    logic       busy2, ov2;
    assign h2.ReqValid = 1'b1;
    assign h2.ReqWrite = 1'b0;
    assign h2.ReqAddr  = 3'd4;
    assign h2.ReqWData = 8'h00;

    dram_row_controller #(.REFRESH_INTERVAL(4)) dut2 (
        .Clock(Clock), .nReset(nReset), .host(h2),
        .WriteEdge(we2), .ReadEdge(re2), .RefreshEdge(rf2),
        .CellInputData(ci2), .CellOutputData(8'h96),
        .Busy(busy2), .RefreshOverrun(ov2)
    );

    // Interval shorter than one refresh: pending is re-armed while still owed
    dram_row_controller_if #(.ADDR_W(3), .WIDTH(8)) h3 ();
    logic [7:0] we3, re3, rf3, ci3;
    logic       busy3, ov3;
    assign h3.ReqValid = 1'b0;
    assign h3.ReqWrite = 1'b0;
    assign h3.ReqAddr  = 3'd0;
    assign h3.ReqWData = 8'h00;

    dram_row_controller #(.REFRESH_INTERVAL(2)) dut3 (
        .Clock(Clock), .nReset(nReset), .host(h3),
        .WriteEdge(we3), .ReadEdge(re3), .RefreshEdge(rf3),
        .CellInputData(ci3), .CellOutputData(8'h00),
        .Busy(busy3), .RefreshOverrun(ov3)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int at;

    int multiEdge  = 0;
    int ov2Count   = 0;
    int rsp2Count  = 0;
    int ov3Count   = 0;
    int ov3Double  = 0;
    logic ov3Prev  = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic waitRefresh(output int when);
        int n;
        n = 0;
        while (refreshEdge == 8'h00 && n < 200) begin
            tick();
            n++;
        end
        if (refreshEdge == 8'h00) checkEq("refresh_timeout", 32'd0, 32'd1);
        when = cyc;
    endtask

    task automatic request(input logic wr, input logic [2:0] addr, input logic [7:0] data);
        h1.ReqValid = 1'b1;
        h1.ReqWrite = wr;
        h1.ReqAddr  = addr;
        h1.ReqWData = data;
    endtask

    // Background observers
    always @(negedge Clock) begin
        if (!nReset) begin
            ov3Prev <= 1'b0;
        end else begin
            if ($countones({writeEdge, readEdge, refreshEdge}) > 1) multiEdge <= multiEdge + 1;
            if (ov2) ov2Count <= ov2Count + 1;
            if (h2.RspValid) rsp2Count <= rsp2Count + 1;
            if (ov3) ov3Count <= ov3Count + 1;
            if (ov3 && ov3Prev) ov3Double <= ov3Double + 1;
            ov3Prev <= ov3;
        end
    end

    initial begin
        h1.ReqValid = 1'b0;
        h1.ReqWrite = 1'b0;
        h1.ReqAddr  = 3'd0;
        h1.ReqWData = 8'h00;
        cellOut     = 8'h00;

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        checkEq("rst_edges", {8'h0, writeEdge, readEdge, refreshEdge}, 32'h0);
        checkEq("rst_cellin", cellIn, 8'h00);
        checkEq("rst_busy", busy, 1'b0);
        checkEq("rst_ready", h1.ReqReady, 1'b1);
        checkEq("rst_rsp", {h1.RspValid, h1.RspRData}, 9'h000);
        @(negedge Clock);
        nReset = 1'b1;
        cyc = 0;

        // Write row 5
        request(1'b1, 3'd5, 8'hA5);
        tick();
        checkEq("wr_edge_c1", writeEdge, 8'b0010_0000);
        checkEq("wr_data_c1", cellIn, 8'hA5);
        checkEq("wr_busy", busy, 1'b1);
        checkEq("wr_ready", h1.ReqReady, 1'b0);
        h1.ReqValid = 1'b0;
        tick();
        checkEq("wr_edge_c2", writeEdge, 8'b0010_0000);
        checkEq("wr_data_c2", cellIn, 8'hA5);
        tick();
        checkEq("wr_recover_edge", writeEdge, 8'h00);
        checkEq("wr_recover_data", cellIn, 8'h00);
        checkEq("wr_recover_rsp", h1.RspValid, 1'b0);
        tick();
        checkEq("wr_ready_c4", h1.ReqReady, 1'b1);
        checkEq("wr_idle_busy", busy, 1'b0);

        // Read row 5
        cellOut = 8'hA5;
        request(1'b0, 3'd5, 8'h00);
        tick();
        checkEq("rd_edge_c1", readEdge, 8'b0010_0000);
        checkEq("rd_nowrite", writeEdge, 8'h00);
        checkEq("ov3_c5", ov3, 1'b0);
        h1.ReqValid = 1'b0;
        tick();
        checkEq("rd_edge_c2", readEdge, 8'b0010_0000);
        checkEq("rd_rsp_c2", h1.RspValid, 1'b0);
        checkEq("ov3_c6", ov3, 1'b1);
        tick();
        checkEq("rd_rsp_c3", h1.RspValid, 1'b1);
        checkEq("rd_data", h1.RspRData, 8'hA5);
        checkEq("rd_recover_edge", readEdge, 8'h00);
        checkEq("ov3_c7", ov3, 1'b0);
        tick();
        checkEq("rd_rsp_c4", h1.RspValid, 1'b0);
        checkEq("rd_data_held", h1.RspRData, 8'hA5);

        // Read row 0 with different data
        cellOut = 8'h5A;
        request(1'b0, 3'd0, 8'h00);
        tick();
        checkEq("rd0_edge", readEdge, 8'h01);
        h1.ReqValid = 1'b0;
        tick();
        tick();
        checkEq("rd0_data", h1.RspRData, 8'h5A);
        checkEq("rd0_rsp", h1.RspValid, 1'b1);
        tick();

        // Distributed refresh, one row per interval, wrapping after 8
        waitRefresh(at);
        checkEq("ref0_cycle", at, 65);
        checkEq("ref0_edge", refreshEdge, 8'h01);
        checkEq("ref0_busy", busy, 1'b1);
        tick();
        checkEq("ref0_edge_c2", refreshEdge, 8'h01);
        tick();
        checkEq("ref0_recover", refreshEdge, 8'h00);
        for (int r = 1; r <= 8; r++) begin
            waitRefresh(at);
            checkEq($sformatf("ref%0d_cycle", r), at, 65 + 64 * r);
            checkEq($sformatf("ref%0d_edge", r), refreshEdge, 32'(8'h01 << (r % 8)));
            tick();
            tick();
        end

        // Host held off while refresh is pending
        while (cyc < 640) tick();
        checkEq("pend_ready", h1.ReqReady, 1'b0);
        request(1'b1, 3'd3, 8'h77);
        tick();
        checkEq("pend_ref_edge", refreshEdge, 8'h02);
        checkEq("pend_no_write", writeEdge, 8'h00);
        tick();
        tick();
        checkEq("pend_recover_ready", h1.ReqReady, 1'b0);
        tick();
        checkEq("pend_idle_ready", h1.ReqReady, 1'b1);
        tick();
        checkEq("pend_wr_edge", writeEdge, 8'b0000_1000);
        checkEq("pend_wr_data", cellIn, 8'h77);
        h1.ReqValid = 1'b0;

        // Request accepted on the terminal-count cycle: request first, refresh next
        while (cyc < 703) tick();
        cellOut = 8'hC3;
        request(1'b0, 3'd6, 8'h00);
        tick();
        checkEq("tc_rd_edge", readEdge, 8'b0100_0000);
        h1.ReqValid = 1'b0;
        tick();
        tick();
        checkEq("tc_rd_data", h1.RspRData, 8'hC3);
        tick();
        checkEq("tc_idle_ready", h1.ReqReady, 1'b0);
        tick();
        checkEq("tc_ref_edge", refreshEdge, 8'h04);

        // Asynchronous reset in the middle of a write
        while (cyc < 720) tick();
        request(1'b1, 3'd1, 8'hFF);
        tick();
        checkEq("mid_wr_edge", writeEdge, 8'h02);
        h1.ReqValid = 1'b0;
        nReset = 1'b0;
        #1;
        checkEq("mid_rst_edges", {8'h0, writeEdge, readEdge, refreshEdge}, 32'h0);
        checkEq("mid_rst_cellin", cellIn, 8'h00);
        checkEq("mid_rst_rsp", h1.RspValid, 1'b0);
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        cyc = 0;
        #1;
        checkEq("post_rst_ready", h1.ReqReady, 1'b1);
        checkEq("post_rst_busy", busy, 1'b0);
        waitRefresh(at);
        checkEq("post_rst_ref_cycle", at, 65);
        checkEq("post_rst_ref_row", refreshEdge, 8'h01);
        tick();
        tick();
        tick();

        // Background results
        checkEq("one_edge_max", multiEdge, 0);
        checkEq("dut2_no_overrun", ov2Count, 0);
        checkEq("dut2_served", rsp2Count != 0, 1'b1);
        checkEq("dut2_rdata", h2.RspRData, 8'h96);
        checkEq("dut3_overrun_seen", ov3Count != 0, 1'b1);
        checkEq("dut3_single_pulse", ov3Double, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
